// File: rtl/railway_pkg.sv
// Shared types and default timing for the multi-track level-crossing controller.
package railway_pkg;

   // Crossing sequence states, 3-bit encoded.
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WARN       = 3'd1,
      LOWERING   = 3'd2,
      CLOSED     = 3'd3,
      CLEAR_WAIT = 3'd4,
      RAISING    = 3'd5
   } state_t;

   // Default cycle parameters shared by the controller and its users.
   localparam int DEF_NUM_TRACKS       = 2;
   localparam int DEF_WARN_CYCLES      = 8;
   localparam int DEF_GATE_MOVE_CYCLES = 4;
   localparam int DEF_CLEAR_CYCLES     = 6;
   localparam int DEF_MAX_OCC_CYCLES   = 1024;

   // Width of every phase/occupancy counter: one bit more than needed
   // for the largest cycle parameter, so saturation sits above all limits.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/railway_track_monitor.sv
// One track's occupancy flag, occupancy timer and sticky timeout flag.
module railway_track_monitor
   import railway_pkg::*;
#(
   parameter int MAX_OCC_CYCLES = DEF_MAX_OCC_CYCLES,
   parameter int CNT_W          = 11
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_approach,
   input  logic i_exit,
   output logic o_occupied,
   output logic o_timeout
);

   localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_OCC_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic             r_occupied;
   logic             r_timeout;
   logic [CNT_W-1:0] r_timer;

   logic             w_occ_next;
   logic [CNT_W-1:0] w_timer_inc;
   logic [CNT_W-1:0] w_timer_next;

   // Approach always wins (back-to-back train); exit only clears a set flag.
   assign w_occ_next   = i_approach | (r_occupied & ~i_exit);
   // Timer saturates at all-ones instead of wrapping back through zero.
   assign w_timer_inc  = (r_timer == '1) ? r_timer : r_timer + CNT_ONE;
   // Timer tracks the occupied flag: it is zero exactly when the track is free.
   assign w_timer_next = w_occ_next ? w_timer_inc : '0;

   // Occupancy, timer and sticky timeout registers.
   // NOTE: reset is sampled on the clock edge (synchronous), so it only
   // appears in this clocked block and never in a sensitivity list.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_occupied <= 1'b0;
         r_timer    <= '0;
         r_timeout  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples
         // pre-edge values regardless of statement order.
         r_occupied <= w_occ_next;
         r_timer    <= w_timer_next;
         if (w_occ_next && (w_timer_next >= TIMEOUT_AT)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign o_occupied = r_occupied;
   assign o_timeout  = r_timeout;

endmodule

// File: rtl/railway_crossing_ctrl.sv
// Multi-track level-crossing controller: per-track occupancy monitors, the
// warn/lower/closed/clear/raise sequencer and the stuck-occupancy fault.
module railway_crossing_ctrl
   import railway_pkg::*;
#(
   parameter int NUM_TRACKS       = DEF_NUM_TRACKS,
   parameter int WARN_CYCLES      = DEF_WARN_CYCLES,
   parameter int GATE_MOVE_CYCLES = DEF_GATE_MOVE_CYCLES,
   parameter int CLEAR_CYCLES     = DEF_CLEAR_CYCLES,
   parameter int MAX_OCC_CYCLES   = DEF_MAX_OCC_CYCLES
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [NUM_TRACKS-1:0] i_train_approach,
   input  logic [NUM_TRACKS-1:0] i_train_exit,
   output logic                  o_signal,
   output logic                  o_gate,
   output logic                  o_gate_moving,
   output logic [NUM_TRACKS-1:0] o_occupied,
   output logic                  o_fault
);

   localparam int CNT_W = cnt_width(WARN_CYCLES, GATE_MOVE_CYCLES,
                                    CLEAR_CYCLES, MAX_OCC_CYCLES);

   // Last count value of each timed phase (phase length minus one).
   localparam logic [CNT_W-1:0] WARN_LAST  = CNT_W'(WARN_CYCLES - 1);
   localparam logic [CNT_W-1:0] GATE_LAST  = CNT_W'(GATE_MOVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t                r_state;
   state_t                w_state_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      w_cnt_next;
   logic [CNT_W-1:0]      w_cnt_inc;

   logic [NUM_TRACKS-1:0] w_occupied;
   logic [NUM_TRACKS-1:0] w_timeout;
   logic                  w_any_req;
   logic                  w_fault;

   // One occupancy monitor per track.
   for (genvar g = 0; g < NUM_TRACKS; g++) begin : g_track
      railway_track_monitor #(
         .MAX_OCC_CYCLES (MAX_OCC_CYCLES),
         .CNT_W          (CNT_W)
      ) u_monitor (
         .i_clk      (i_clk),
         .i_reset    (i_reset),
         .i_approach (i_train_approach[g]),
         .i_exit     (i_train_exit[g]),
         .o_occupied (w_occupied[g]),
         .o_timeout  (w_timeout[g])
      );
   end

   // A live approach counts immediately so the warning starts one edge later.
   assign w_any_req = (|i_train_approach) | (|w_occupied);
   // Each monitor's timeout is already sticky, so the OR is sticky too.
   assign w_fault   = |w_timeout;
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE;

   // State and phase counter registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state, counter update and Moore outputs of the crossing sequence.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // can leave one unassigned and infer a latch.
      w_state_next  = r_state;
      w_cnt_next    = w_cnt_inc;
      o_signal      = 1'b0;
      o_gate        = 1'b0;
      o_gate_moving = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_cnt_next = '0;
            if (w_any_req || w_fault) begin
               w_state_next = WARN;
            end
         end

         // Fixed-length phase; new requests never extend it.
         WARN: begin
            o_signal = 1'b1;
            if (r_cnt >= WARN_LAST) begin
               w_state_next = LOWERING;
               w_cnt_next   = '0;
            end
         end

         LOWERING: begin
            o_signal      = 1'b1;
            o_gate        = 1'b1;
            o_gate_moving = 1'b1;
            if (r_cnt >= GATE_LAST) begin
               w_state_next = CLOSED;
               w_cnt_next   = '0;
            end
         end

         // Held while any track is occupied or the fault is latched.
         CLOSED: begin
            o_signal   = 1'b1;
            o_gate     = 1'b1;
            w_cnt_next = '0;
            if (!w_any_req && !w_fault) begin
               w_state_next = CLEAR_WAIT;
            end
         end

         CLEAR_WAIT: begin
            o_signal = 1'b1;
            o_gate   = 1'b1;
            if (w_any_req || w_fault) begin
               w_state_next = CLOSED;
               w_cnt_next   = '0;
            end else if (r_cnt >= CLEAR_LAST) begin
               w_state_next = RAISING;
               w_cnt_next   = '0;
            end
         end

         // A new request reverses the gate with a full lowering travel.
         RAISING: begin
            o_signal      = 1'b1;
            o_gate_moving = 1'b1;
            if (w_any_req || w_fault) begin
               w_state_next = LOWERING;
               w_cnt_next   = '0;
            end else if (r_cnt >= GATE_LAST) begin
               w_state_next = IDLE;
               w_cnt_next   = '0;
            end
         end

         default: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   assign o_occupied = w_occupied;
   assign o_fault    = w_fault;

endmodule
